// File: rtl/countdown_timer_param.sv
// Parametrised game countdown timer: preset entry in IDLE, 100 ms countdown with pause,
// bonus time, low-time warning and BCD digit outputs for the seven-segment muxes.
module countdown_timer_param #(
  parameter int MAX_MIN   = 9,
  parameter int STEP_SEC  = 10,
  parameter int DEF_SEC   = 20,
  parameter int WARN_SEC  = 10,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  input  logic       game_over,
  input  logic       key_up,
  input  logic       key_dn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       time_out,
  output logic       expire_p,
  output logic       warn
);

  localparam int RMAX = MAX_MIN * 600 + 599;
  localparam int PMAX = ((MAX_MIN * 60 + 59) / STEP_SEC) * STEP_SEC;
  localparam int W    = $clog2(RMAX + 1);

  localparam logic [W-1:0] STEP_V  = W'(STEP_SEC);
  localparam logic [W-1:0] PMAX_V  = W'(PMAX);
  localparam logic [W-1:0] DEF_V   = W'(DEF_SEC);
  localparam logic [W-1:0] WARN_V  = W'(WARN_SEC * 10);
  localparam logic [W:0]   RMAX_X  = (W+1)'(RMAX);
  localparam logic [W:0]   BONUS_X = (W+1)'(BONUS_SEC * 10);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, EXPIRED, STOPPED} state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] remaining_reg, remaining_next;
  logic [W-1:0] preset_reg, preset_next;
  logic         expire_p_reg, expire_p_next;
  logic [1:0]   keys, key_edge;

  assign keys = {key_dn, key_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic key_q_reg;
      always_ff @(posedge clk) begin
        if (!rst) key_q_reg <= 1'b0;
        else      key_q_reg <= keys[gi];
      end
      assign key_edge[gi] = keys[gi] & ~key_q_reg;
    end
  endgenerate

  // Bonus and tick are applied together before clamping; remaining is never 0 in RUN/PAUSE.
  function automatic logic [W-1:0] add_time(input logic [W-1:0] rem,
                                            input logic add_bonus,
                                            input logic sub_tick);
    logic [W:0] t;
    t = {1'b0, rem};
    if (add_bonus) t = t + BONUS_X;
    if (sub_tick)  t = t - (W+1)'(1);
    if (t > RMAX_X) t = RMAX_X;
    return t[W-1:0];
  endfunction

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    preset_next    = preset_reg;
    expire_p_next  = 1'b0;

    if (state_reg == IDLE) begin
      if (key_edge == 2'b01)
        preset_next = (preset_reg >= PMAX_V) ? STEP_V : preset_reg + STEP_V;
      else if (key_edge == 2'b10)
        preset_next = (preset_reg <= STEP_V) ? PMAX_V : preset_reg - STEP_V;
    end

    if (game_over) begin
      state_next     = STOPPED;
      remaining_next = '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          state_next     = RUN;
          remaining_next = preset_reg * W'(10);
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else begin
            remaining_next = add_time(remaining_reg, bonus, tick_100ms);
            if (add_time(remaining_reg, bonus, tick_100ms) == '0) begin
              state_next    = EXPIRED;
              expire_p_next = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (pause) state_next = RUN;
          else       remaining_next = add_time(remaining_reg, bonus, 1'b0);
        end
        EXPIRED, STOPPED: if (start) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      preset_reg    <= DEF_V;
      remaining_reg <= '0;
      expire_p_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      preset_reg    <= preset_next;
      remaining_reg <= remaining_next;
      expire_p_reg  <= expire_p_next;
    end
  end

  // Displayed value in tenths, decoded into BCD fields.
  logic [W-1:0] shown, secs_total, mins;

  always_comb begin
    case (state_reg)
      IDLE:       shown = preset_reg * W'(10);
      RUN, PAUSE: shown = remaining_reg;
      default:    shown = '0;
    endcase
    secs_total = shown / W'(10);
    mins       = secs_total / W'(60);
  end

  assign tenths   = 4'(shown % W'(10));
  assign sec_ones = 4'((secs_total % W'(60)) % W'(10));
  assign sec_tens = 4'((secs_total % W'(60)) / W'(10));
  assign min_ones = 4'(mins % W'(10));
  assign min_tens = 4'(mins / W'(10));

  assign running  = (state_reg == RUN);
  assign time_out = (state_reg == EXPIRED);
  assign expire_p = expire_p_reg;
  assign warn     = ((state_reg == RUN) || (state_reg == PAUSE)) &&
                    (remaining_reg != '0) && (remaining_reg < WARN_V);

endmodule
